// File: rtl/adsr_envelope.sv
// ADSR envelope generator: gate-driven four-stage amplitude envelope.
// Level arithmetic runs on a prescaled tick; gate transitions act every clock.
module adsr_envelope #(
  parameter int unsigned PRESCALE = 50
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_gate,
  input  logic [15:0] i_attack,
  input  logic [15:0] i_decay,
  input  logic [15:0] i_sustain,
  input  logic [15:0] i_release,
  output logic [15:0] o_amp,
  output logic [2:0]  o_state,
  output logic        o_active
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam logic [15:0] TICK_AT = 16'(PRESCALE - 1);

  state_t      state_q, state_d;
  logic [15:0] level_q, level_d;
  logic [15:0] cnt_q, cnt_d;
  logic        active_q, active_d;
  logic        tick;

  logic [16:0] att_sum;
  logic [16:0] dec_gap;

  // Free-running prescaler, never restarted by the gate.
  assign tick  = (cnt_q == TICK_AT);
  assign cnt_d = tick ? '0 : cnt_q + 16'd1;

  assign att_sum = {1'b0, level_q} + {1'b0, i_attack};
  assign dec_gap = {1'b0, level_q} - {1'b0, i_sustain};

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    // Gate transitions win over tick arithmetic and hold the level.
    if ((state_q == ST_IDLE || state_q == ST_RELEASE) && i_gate) begin
      state_d = ST_ATTACK;
    end else if ((state_q == ST_ATTACK || state_q == ST_DECAY ||
                  state_q == ST_SUSTAIN) && !i_gate) begin
      state_d = ST_RELEASE;
    end else if (tick) begin
      unique case (state_q)
        ST_ATTACK: begin
          if (i_attack == '0 || att_sum >= 17'h0FFFF) begin
            level_d = '1;
            state_d = ST_DECAY;
          end else begin
            level_d = att_sum[15:0];
          end
        end
        ST_DECAY: begin
          if (i_decay == '0 || level_q <= i_sustain ||
              dec_gap <= {1'b0, i_decay}) begin
            level_d = i_sustain;
            state_d = ST_SUSTAIN;
          end else begin
            level_d = level_q - i_decay;
          end
        end
        ST_SUSTAIN: level_d = i_sustain;
        ST_RELEASE: begin
          if (i_release == '0 || level_q <= i_release) begin
            level_d = '0;
            state_d = ST_IDLE;
          end else begin
            level_d = level_q - i_release;
          end
        end
        default: level_d = '0;
      endcase
    end
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      level_q  <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign o_amp    = level_q;
  assign o_state  = state_q;
  assign o_active = active_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope with PRESCALE=4; tick phase is tracked
// independently by counting clock edges since reset release.
module tb_adsr_envelope;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gate = 1'b0;
  logic [15:0] attack = '0, decay = '0, sustain = '0, rel = '0;
  logic [15:0] amp;
  logic [2:0]  state;
  logic        active;

  int n_cmp = 0;
  int n_bad = 0;
  int edges = 0;

  adsr_envelope #(.PRESCALE(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_gate(gate),
    .i_attack(attack), .i_decay(decay), .i_sustain(sustain), .i_release(rel),
    .o_amp(amp), .o_state(state), .o_active(active)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Advance to just after the next edge on which the prescaler ticks.
  task automatic wait_tick;
    int k = 0;
    do begin
      step();
      k++;
    end while (!((edges % 4) == 0) && k < 8);
    if (k >= 8) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_tick: no tick within 8 clocks (edges=%0d)", edges);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    gate = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  task automatic set_note;
    attack = 16'h4000; decay = 16'h1000; sustain = 16'hC000; rel = 16'h8000;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if ({amp, state, active} !== {16'h0000, 3'd0, 1'b0}) begin
      n_bad++; $display("FAIL reset_initial: got amp=%h st=%0d act=%b want 0000/0/0", amp, state, active);
    end
    set_note();
    @(posedge clk); #3; rst = 1'b0;
    gate = 1'b1;
    wait_tick(); wait_tick();
    n_cmp++;
    if ({amp, state} !== {16'h8000, 3'd1}) begin
      n_bad++; $display("FAIL reset_pre: got amp=%h st=%0d want 8000/1", amp, state);
    end
    #2; rst = 1'b1; #1;
    n_cmp++;
    if ({amp, state, active} !== {16'h0000, 3'd0, 1'b0}) begin
      n_bad++; $display("FAIL reset_async: got amp=%h st=%0d act=%b want 0000/0/0", amp, state, active);
    end
    @(posedge clk); #3; rst = 1'b0;
    step(); step(); step();
    n_cmp++;
    if ({amp, state} !== {16'h0000, 3'd1}) begin
      n_bad++; $display("FAIL reset_no_early_tick: got amp=%h st=%0d want 0000/1", amp, state);
    end
    step();
    n_cmp++;
    if (amp !== 16'h4000) begin
      n_bad++; $display("FAIL reset_first_tick: got amp=%h want 4000", amp);
    end
  endtask

  task automatic test_full_note;
    logic [15:0] exp_a [8] = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF,
                               16'hEFFF, 16'hDFFF, 16'hCFFF, 16'hC000};
    logic [2:0]  exp_s [8] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
    do_reset(); set_note(); gate = 1'b1;
    step();
    n_cmp++;
    if ({amp, state, active} !== {16'h0000, 3'd1, 1'b1}) begin
      n_bad++; $display("FAIL note_gate_on: got amp=%h st=%0d act=%b want 0000/1/1", amp, state, active);
    end
    for (int i = 0; i < 8; i++) begin
      wait_tick();
      n_cmp++;
      if ({amp, state} !== {exp_a[i], exp_s[i]}) begin
        n_bad++; $display("FAIL note_tick%0d: got amp=%h st=%0d want %h/%0d", i, amp, state, exp_a[i], exp_s[i]);
      end
    end
    gate = 1'b0;
    step();
    n_cmp++;
    if ({amp, state} !== {16'hC000, 3'd4}) begin
      n_bad++; $display("FAIL note_gate_off: got amp=%h st=%0d want C000/4", amp, state);
    end
    wait_tick();
    n_cmp++;
    if ({amp, state} !== {16'h4000, 3'd4}) begin
      n_bad++; $display("FAIL note_rel1: got amp=%h st=%0d want 4000/4", amp, state);
    end
    wait_tick();
    n_cmp++;
    if ({amp, state, active} !== {16'h0000, 3'd0, 1'b0}) begin
      n_bad++; $display("FAIL note_rel2: got amp=%h st=%0d act=%b want 0000/0/0", amp, state, active);
    end
  endtask

  task automatic test_instant;
    do_reset();
    attack = '0; decay = '0; rel = '0; sustain = 16'h2000; gate = 1'b1;
    step();
    wait_tick();
    n_cmp++;
    if ({amp, state} !== {16'hFFFF, 3'd2}) begin
      n_bad++; $display("FAIL inst_attack: got amp=%h st=%0d want FFFF/2", amp, state);
    end
    wait_tick();
    n_cmp++;
    if ({amp, state} !== {16'h2000, 3'd3}) begin
      n_bad++; $display("FAIL inst_decay: got amp=%h st=%0d want 2000/3", amp, state);
    end
    gate = 1'b0;
    wait_tick();
    n_cmp++;
    if ({amp, state, active} !== {16'h0000, 3'd0, 1'b0}) begin
      n_bad++; $display("FAIL inst_release: got amp=%h st=%0d act=%b want 0000/0/0", amp, state, active);
    end
  endtask

  task automatic test_retrigger;
    do_reset(); set_note(); gate = 1'b1;
    for (int i = 0; i < 8; i++) wait_tick();
    gate = 1'b0;
    wait_tick();
    n_cmp++;
    if ({amp, state} !== {16'h4000, 3'd4}) begin
      n_bad++; $display("FAIL retrig_rel: got amp=%h st=%0d want 4000/4", amp, state);
    end
    gate = 1'b1;
    step();
    n_cmp++;
    if ({amp, state} !== {16'h4000, 3'd1}) begin
      n_bad++; $display("FAIL retrig_attack: got amp=%h st=%0d want 4000/1", amp, state);
    end
    wait_tick();
    n_cmp++;
    if ({amp, state} !== {16'h8000, 3'd1}) begin
      n_bad++; $display("FAIL retrig_tick: got amp=%h st=%0d want 8000/1", amp, state);
    end
  endtask

  task automatic test_simultaneous;
    do_reset(); set_note(); gate = 1'b1;
    for (int i = 0; i < 3; i++) wait_tick();
    step(); step(); step();
    gate = 1'b0;
    step();
    n_cmp++;
    if ({amp, state} !== {16'hC000, 3'd4}) begin
      n_bad++; $display("FAIL simul_edge: got amp=%h st=%0d want C000/4", amp, state);
    end
    wait_tick();
    n_cmp++;
    if ({amp, state} !== {16'h4000, 3'd4}) begin
      n_bad++; $display("FAIL simul_release: got amp=%h st=%0d want 4000/4", amp, state);
    end
  endtask

  task automatic test_sustain_track;
    do_reset(); set_note(); gate = 1'b1;
    for (int i = 0; i < 8; i++) wait_tick();
    sustain = 16'h1000;
    step(); step(); step();
    n_cmp++;
    if ({amp, state} !== {16'hC000, 3'd3}) begin
      n_bad++; $display("FAIL track_hold: got amp=%h st=%0d want C000/3", amp, state);
    end
    step();
    n_cmp++;
    if ({amp, state} !== {16'h1000, 3'd3}) begin
      n_bad++; $display("FAIL track_step: got amp=%h st=%0d want 1000/3", amp, state);
    end
  endtask

  task automatic test_sustain_max;
    do_reset(); set_note(); sustain = 16'hFFFF; gate = 1'b1;
    for (int i = 0; i < 4; i++) wait_tick();
    n_cmp++;
    if ({amp, state} !== {16'hFFFF, 3'd2}) begin
      n_bad++; $display("FAIL smax_peak: got amp=%h st=%0d want FFFF/2", amp, state);
    end
    wait_tick();
    n_cmp++;
    if ({amp, state} !== {16'hFFFF, 3'd3}) begin
      n_bad++; $display("FAIL smax_decay: got amp=%h st=%0d want FFFF/3", amp, state);
    end
  endtask

  task automatic test_gate_pulse;
    do_reset(); set_note();
    wait_tick();
    gate = 1'b1;
    step();
    gate = 1'b0;
    n_cmp++;
    if ({amp, state} !== {16'h0000, 3'd1}) begin
      n_bad++; $display("FAIL pulse_attack: got amp=%h st=%0d want 0000/1", amp, state);
    end
    step();
    n_cmp++;
    if ({amp, state, active} !== {16'h0000, 3'd4, 1'b1}) begin
      n_bad++; $display("FAIL pulse_release: got amp=%h st=%0d act=%b want 0000/4/1", amp, state, active);
    end
    wait_tick();
    n_cmp++;
    if ({amp, state, active} !== {16'h0000, 3'd0, 1'b0}) begin
      n_bad++; $display("FAIL pulse_idle: got amp=%h st=%0d act=%b want 0000/0/0", amp, state, active);
    end
  endtask

  initial begin
    test_reset();
    test_full_note();
    test_instant();
    test_retrigger();
    test_simultaneous();
    test_sustain_track();
    test_sustain_max();
    test_gate_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
